// File: rtl/logicnets_pkg.sv
// logicnets_pkg: shared FSM state encoding, default sizes and helpers for the LogicNets LUT layer
package logicnets_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CFG   = 2'd2
    } lut_state_t;

    localparam int DEF_NEURONS  = 4;
    localparam int DEF_IN_BITS  = 7;
    localparam int DEF_OUT_BITS = 2;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logicnets_lut_bank.sv
// logicnets_lut_bank: one neuron table with a write port and a registered lookup port
// LUT_READBACK_EN adds a second registered read port addressed by the configuration bus.
module logicnets_lut_bank
    import logicnets_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [IN_BITS-1:0]  i_waddr,
    input  logic [OUT_BITS-1:0] i_wdata,
    input  logic                i_re,
    input  logic [IN_BITS-1:0]  i_raddr,
`ifdef LUT_READBACK_EN
    output logic [OUT_BITS-1:0] o_rdata,
    input  logic [IN_BITS-1:0]  i_cfg_addr,
    output logic [OUT_BITS-1:0] o_cfg_rdata
`else
    output logic [OUT_BITS-1:0] o_rdata
`endif
);

    logic [OUT_BITS-1:0] r_mem [2**IN_BITS];
    logic [OUT_BITS-1:0] r_rdata;

    // Table write port; contents are intentionally left untouched by reset
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Lookup register feeding the output stage, only advanced when the stage moves
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

`ifdef LUT_READBACK_EN
    logic [OUT_BITS-1:0] r_cfg_rdata;

    // Free-running readback register addressed by the configuration bus
    always_ff @(posedge clk) begin
        if (rst) r_cfg_rdata <= '0;
        else r_cfg_rdata <= r_mem[i_cfg_addr];
    end

    assign o_cfg_rdata = r_cfg_rdata;
`endif

endmodule

// File: rtl/logicnets_lut_layer.sv
// logicnets_lut_layer: two-stage LUT neuron layer with drain-then-configure table writes
// Optional macro LUT_READBACK_EN adds the registered cfg_rdata readback port.
module logicnets_lut_layer
    import logicnets_pkg::*;
#(
    parameter int NEURONS  = DEF_NEURONS,
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NEURONS*IN_BITS-1:0]     in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NEURONS*OUT_BITS-1:0]    out_data,
    input  logic                           cfg_req,
    output logic                           cfg_ack,
    input  logic                           cfg_we,
    input  logic [sel_width(NEURONS)-1:0]  cfg_neuron,
    input  logic [IN_BITS-1:0]             cfg_addr,
`ifdef LUT_READBACK_EN
    input  logic [OUT_BITS-1:0]            cfg_data,
    output logic [OUT_BITS-1:0]            cfg_rdata
`else
    input  logic [OUT_BITS-1:0]            cfg_data
`endif
);

    localparam int NW = sel_width(NEURONS);

    lut_state_t                 r_state;
    lut_state_t                 w_next;
    logic                       r_s1_valid;
    logic                       r_s2_valid;
    logic [NEURONS*IN_BITS-1:0] r_s1_addr;
    logic                       w_s2_ready;
    logic                       w_s1_open;
    logic                       w_in_fire;
    logic                       w_cfg_wr;

    // Stage 2 can load when empty or when its word leaves; stage 1 likewise behind it.
    // A pending cfg_req already blocks new words so nothing enters once draining starts.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_open  = !r_s1_valid || w_s2_ready;
    assign in_ready   = (r_state == ST_RUN) && !cfg_req && w_s1_open;
    assign w_in_fire  = in_valid && in_ready;
    assign w_cfg_wr   = (r_state == ST_CFG) && cfg_we;
    assign out_valid  = r_s2_valid;
    assign cfg_ack    = (r_state == ST_CFG);

    // Next state: dropping cfg_req always returns to RUN, DRAIN waits for both stages to empty
    always_comb begin
        w_next = !cfg_req               ? ST_RUN   :
                 (r_state == ST_RUN)    ? ST_DRAIN :
                 (r_state == ST_DRAIN)  ? ((!r_s1_valid && !r_s2_valid) ? ST_CFG : ST_DRAIN) :
                 (r_state == ST_CFG)    ? ST_CFG   : ST_RUN;
    end

    // Mode register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else r_state <= w_next;
    end

    // Stage 1: capture the per-neuron addresses of an accepted word
    always_ff @(posedge clk) begin
        if (rst) r_s1_valid <= 1'b0;
        else if (w_s1_open) r_s1_valid <= w_in_fire;
        if (w_in_fire) r_s1_addr <= in_data;
    end

    // Stage 2 valid flag; the data half lives in each bank's lookup register
    always_ff @(posedge clk) begin
        if (rst) r_s2_valid <= 1'b0;
        else if (w_s2_ready) r_s2_valid <= r_s1_valid;
    end

`ifdef LUT_READBACK_EN
    logic [NW-1:0]       r_cfg_sel;
    logic [OUT_BITS-1:0] w_cfg_rd [NEURONS];

    // Remember which neuron the banks' readback registers were addressed for
    always_ff @(posedge clk) begin
        if (rst) r_cfg_sel <= '0;
        else r_cfg_sel <= cfg_neuron;
    end

    // Readback select, zero outside CFG and for neuron indices that do not exist
    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < NEURONS; i++)
            if ((r_state == ST_CFG) && (r_cfg_sel == NW'(i))) cfg_rdata = w_cfg_rd[i];
    end
`endif

    for (genvar n = 0; n < NEURONS; n++) begin : g_bank
        logicnets_lut_bank #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .i_we        (w_cfg_wr && (cfg_neuron == NW'(n))),
            .i_waddr     (cfg_addr),
            .i_wdata     (cfg_data),
            .i_re        (w_s2_ready && r_s1_valid),
            .i_raddr     (r_s1_addr[n*IN_BITS +: IN_BITS]),
`ifdef LUT_READBACK_EN
            .o_rdata     (out_data[n*OUT_BITS +: OUT_BITS]),
            .i_cfg_addr  (cfg_addr),
            .o_cfg_rdata (w_cfg_rd[n])
`else
            .o_rdata     (out_data[n*OUT_BITS +: OUT_BITS])
`endif
        );
    end

endmodule
